// File: rtl/exec_pipe_unit_pkg.sv
// Shared types and constants for the exec_pipe_unit execute stage.
// The multiply ops are always enumerated; they only execute when EXEC_PIPE_MUL_EN is defined.
package exec_pipe_unit_pkg;

    typedef enum logic [5:0] {
        OP_NOP    = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
    } exec_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, MUL} exec_state_t;

    localparam int unsigned PC_STEP    = 4;
    localparam logic [63:0] DIV_ZERO_Q = '1;

    function automatic logic is_imm_op(input exec_op_t op);
        return op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                          OP_SLLI, OP_SRLI, OP_SRAI};
    endfunction

    function automatic logic is_div_op(input exec_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_mul_op(input exec_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/exec_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, XLEN cycles per divide.
// done is high during the cycle whose clock edge retires the final iteration.
module exec_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;

    // The extra top bit of diff is the borrow: set means the trial subtraction failed.
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
        end else if (busy_q) begin
            if (diff[XLEN]) begin
                rem_d = rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && !abort && (cnt_q == CNT_W'(XLEN-1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/exec_pipe_unit.sv
// RV32I/RV64I execute stage with registered writeback record, branch resolution and iterative divide.
// Define EXEC_PIPE_MUL_EN to add the two-cycle MUL/MULH/MULHSU/MULHU path.
module exec_pipe_unit
    import exec_pipe_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHAMT_W    = $clog2(XLEN),
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  exec_op_t              in_op,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1_val,
    input  logic [XLEN-1:0]       in_rs2_val,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic [XLEN-1:0]       out_rd_value,
    output logic [XLEN-1:0]       out_next_pc,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic                  misalign
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    exec_state_t state_q, state_d;

    logic                  out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;
    logic                  out_rd_we_q, out_rd_we_d;
    logic [XLEN-1:0]       out_rd_value_q, out_rd_value_d;
    logic [XLEN-1:0]       out_next_pc_q, out_next_pc_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
    logic                  misalign_q, misalign_d;

    logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
    logic [XLEN-1:0]       pend_pc_q, pend_pc_d;
    logic [XLEN-1:0]       pend_value_q, pend_value_d;
    logic                  pend_special_q, pend_special_d;
    logic                  pend_rem_q, pend_rem_d;
    logic                  pend_qneg_q, pend_qneg_d;
    logic                  pend_rneg_q, pend_rneg_d;

`ifdef EXEC_PIPE_MUL_EN
    exec_op_t              mul_op_q, mul_op_d;
    logic [XLEN-1:0]       mul_a_q, mul_a_d;
    logic [XLEN-1:0]       mul_b_q, mul_b_d;
    logic [2*XLEN-1:0]     mul_a_ext, mul_b_ext, mul_prod;
    logic [XLEN-1:0]       mul_result;
`endif

    logic                  out_free, accept;
    logic [XLEN-1:0]       op_b, link, jalr_sum;
    logic [SHAMT_W-1:0]    shamt;
    logic [XLEN-1:0]       sc_value, sc_target, sc_next_pc;
    logic                  sc_writes, sc_taken, sc_misalign, sc_we;

    logic                  div_signed, div_is_rem, div_a_neg, div_b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]       div_a_abs, div_b_abs, div_special_value;
    logic                  div_start, div_abort, div_busy, div_done;
    logic [XLEN-1:0]       div_quo, div_rem, div_q_fix, div_r_fix;

    // Single-cycle datapath: result, target and write enable for whatever op sits on the inputs.
    always_comb begin
        op_b      = is_imm_op(in_op) ? in_imm : in_rs2_val;
        shamt     = op_b[SHAMT_W-1:0];
        link      = in_pc + STEP;
        jalr_sum  = in_rs1_val + in_imm;
        sc_value  = '0;
        sc_writes = 1'b0;
        sc_taken  = 1'b0;
        sc_target = in_pc + in_imm;
        case (in_op)
            OP_ADD, OP_ADDI:   begin sc_value = in_rs1_val + op_b; sc_writes = 1'b1; end
            OP_SUB:            begin sc_value = in_rs1_val - op_b; sc_writes = 1'b1; end
            OP_SLL, OP_SLLI:   begin sc_value = in_rs1_val << shamt; sc_writes = 1'b1; end
            OP_SLT, OP_SLTI:   begin sc_value = XLEN'($signed(in_rs1_val) < $signed(op_b)); sc_writes = 1'b1; end
            OP_SLTU, OP_SLTIU: begin sc_value = XLEN'(in_rs1_val < op_b); sc_writes = 1'b1; end
            OP_XOR, OP_XORI:   begin sc_value = in_rs1_val ^ op_b; sc_writes = 1'b1; end
            OP_SRL, OP_SRLI:   begin sc_value = in_rs1_val >> shamt; sc_writes = 1'b1; end
            OP_SRA, OP_SRAI:   begin sc_value = $signed(in_rs1_val) >>> shamt; sc_writes = 1'b1; end
            OP_OR, OP_ORI:     begin sc_value = in_rs1_val | op_b; sc_writes = 1'b1; end
            OP_AND, OP_ANDI:   begin sc_value = in_rs1_val & op_b; sc_writes = 1'b1; end
            OP_LUI:            begin sc_value = in_imm; sc_writes = 1'b1; end
            OP_AUIPC:          begin sc_value = in_pc + in_imm; sc_writes = 1'b1; end
            OP_JAL:            begin sc_value = link; sc_writes = 1'b1; sc_taken = 1'b1; end
            OP_JALR: begin
                sc_value  = link;
                sc_writes = 1'b1;
                sc_taken  = 1'b1;
                sc_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BEQ:  sc_taken = (in_rs1_val == in_rs2_val);
            OP_BNE:  sc_taken = (in_rs1_val != in_rs2_val);
            OP_BLT:  sc_taken = ($signed(in_rs1_val) < $signed(in_rs2_val));
            OP_BGE:  sc_taken = ($signed(in_rs1_val) >= $signed(in_rs2_val));
            OP_BLTU: sc_taken = (in_rs1_val < in_rs2_val);
            OP_BGEU: sc_taken = (in_rs1_val >= in_rs2_val);
            default: ;
        endcase
        sc_misalign = sc_taken && (sc_target[1:0] != 2'b00);
        sc_we       = sc_writes && (in_rd != '0) && !sc_misalign;
        sc_next_pc  = sc_taken ? sc_target : link;
    end

    // Divide setup: the core sees magnitudes; sign fix and the two bypass cases live here.
    always_comb begin
        div_signed = (in_op == OP_DIV) || (in_op == OP_REM);
        div_is_rem = (in_op == OP_REM) || (in_op == OP_REMU);
        div_a_neg  = div_signed && in_rs1_val[XLEN-1];
        div_b_neg  = div_signed && in_rs2_val[XLEN-1];
        div_a_abs  = div_a_neg ? -in_rs1_val : in_rs1_val;
        div_b_abs  = div_b_neg ? -in_rs2_val : in_rs2_val;
        div_zero   = (in_rs2_val == '0);
        div_ovf    = div_signed && (in_rs1_val == XMIN) && (in_rs2_val == '1);
        if (div_zero) begin
            div_special_value = div_is_rem ? in_rs1_val : DIV_ZERO_Q[XLEN-1:0];
        end else begin
            div_special_value = div_is_rem ? '0 : XMIN;
        end
        div_q_fix = pend_qneg_q ? -div_quo : div_quo;
        div_r_fix = pend_rneg_q ? -div_rem : div_rem;
    end

`ifdef EXEC_PIPE_MUL_EN
    always_comb begin
        mul_a_ext  = {{XLEN{mul_a_q[XLEN-1] & (mul_op_q inside {OP_MULH, OP_MULHSU})}}, mul_a_q};
        mul_b_ext  = {{XLEN{mul_b_q[XLEN-1] & (mul_op_q == OP_MULH)}}, mul_b_q};
        mul_prod   = mul_a_ext * mul_b_ext;
        mul_result = (mul_op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end
`endif

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && out_free;
    assign accept    = in_valid && in_ready && !flush;
    assign div_abort = flush;

    // Control FSM and output record; flush is applied last so it overrides every other update.
    always_comb begin
        state_d          = state_q;
        out_valid_d      = out_valid_q && !out_ready;
        out_rd_d         = out_rd_q;
        out_rd_we_d      = out_rd_we_q;
        out_rd_value_d   = out_rd_value_q;
        out_next_pc_d    = out_next_pc_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        misalign_d       = misalign_q;
        pend_rd_d        = pend_rd_q;
        pend_pc_d        = pend_pc_q;
        pend_value_d     = pend_value_q;
        pend_special_d   = pend_special_q;
        pend_rem_d       = pend_rem_q;
        pend_qneg_d      = pend_qneg_q;
        pend_rneg_d      = pend_rneg_q;
        div_start        = 1'b0;
`ifdef EXEC_PIPE_MUL_EN
        mul_op_d         = mul_op_q;
        mul_a_d          = mul_a_q;
        mul_b_d          = mul_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_div_op(in_op)) begin
                        pend_rd_d      = in_rd;
                        pend_pc_d      = in_pc;
                        pend_rem_d     = div_is_rem;
                        pend_qneg_d    = div_a_neg ^ div_b_neg;
                        pend_rneg_d    = div_a_neg;
                        pend_special_d = div_zero || div_ovf;
                        pend_value_d   = div_special_value;
                        if (div_zero || div_ovf) begin
                            state_d = DONE;
                        end else begin
                            div_start = 1'b1;
                            state_d   = BUSY;
                        end
                    end
`ifdef EXEC_PIPE_MUL_EN
                    else if (is_mul_op(in_op)) begin
                        pend_rd_d = in_rd;
                        pend_pc_d = in_pc;
                        mul_op_d  = in_op;
                        mul_a_d   = in_rs1_val;
                        mul_b_d   = in_rs2_val;
                        state_d   = MUL;
                    end
`endif
                    else begin
                        out_valid_d      = 1'b1;
                        out_rd_d         = in_rd;
                        out_rd_we_d      = sc_we;
                        out_rd_value_d   = sc_value;
                        out_next_pc_d    = sc_next_pc;
                        redirect_valid_d = sc_taken;
                        redirect_pc_d    = sc_taken ? sc_target : '0;
                        misalign_d       = sc_misalign;
                    end
                end
            end
            BUSY: begin
                if (div_done) begin
                    state_d = DONE;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (out_free) begin
                    out_valid_d    = 1'b1;
                    out_rd_d       = pend_rd_q;
                    out_rd_we_d    = (pend_rd_q != '0);
                    out_rd_value_d = pend_special_q ? pend_value_q :
                                     (pend_rem_q ? div_r_fix : div_q_fix);
                    out_next_pc_d  = pend_pc_q + STEP;
                    redirect_pc_d  = '0;
                    misalign_d     = 1'b0;
                    state_d        = IDLE;
                end
            end
            MUL: begin
`ifdef EXEC_PIPE_MUL_EN
                if (out_free) begin
                    out_valid_d    = 1'b1;
                    out_rd_d       = pend_rd_q;
                    out_rd_we_d    = (pend_rd_q != '0);
                    out_rd_value_d = mul_result;
                    out_next_pc_d  = pend_pc_q + STEP;
                    redirect_pc_d  = '0;
                    misalign_d     = 1'b0;
                    state_d        = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d          = IDLE;
            out_valid_d      = 1'b0;
            redirect_valid_d = 1'b0;
            div_start        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            out_valid_q      <= 1'b0;
            out_rd_q         <= '0;
            out_rd_we_q      <= 1'b0;
            out_rd_value_q   <= '0;
            out_next_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_q       <= 1'b0;
            pend_rd_q        <= '0;
            pend_pc_q        <= '0;
            pend_value_q     <= '0;
            pend_special_q   <= 1'b0;
            pend_rem_q       <= 1'b0;
            pend_qneg_q      <= 1'b0;
            pend_rneg_q      <= 1'b0;
`ifdef EXEC_PIPE_MUL_EN
            mul_op_q         <= OP_NOP;
            mul_a_q          <= '0;
            mul_b_q          <= '0;
`endif
        end else begin
            state_q          <= state_d;
            out_valid_q      <= out_valid_d;
            out_rd_q         <= out_rd_d;
            out_rd_we_q      <= out_rd_we_d;
            out_rd_value_q   <= out_rd_value_d;
            out_next_pc_q    <= out_next_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_q       <= misalign_d;
            pend_rd_q        <= pend_rd_d;
            pend_pc_q        <= pend_pc_d;
            pend_value_q     <= pend_value_d;
            pend_special_q   <= pend_special_d;
            pend_rem_q       <= pend_rem_d;
            pend_qneg_q      <= pend_qneg_d;
            pend_rneg_q      <= pend_rneg_d;
`ifdef EXEC_PIPE_MUL_EN
            mul_op_q         <= mul_op_d;
            mul_a_q          <= mul_a_d;
            mul_b_q          <= mul_b_d;
`endif
        end
    end

    exec_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (div_a_abs),
        .divisor   (div_b_abs),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign out_valid      = out_valid_q;
    assign out_rd         = out_rd_q;
    assign out_rd_we      = out_rd_we_q;
    assign out_rd_value   = out_rd_value_q;
    assign out_next_pc    = out_next_pc_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_exec_pipe_unit.sv
// Directed self-checking bench for exec_pipe_unit (XLEN=32, default build without multiplier).
module tb_exec_pipe_unit;
    import exec_pipe_unit_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    exec_op_t    in_op;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rd, out_rd;
    logic        out_rd_we, redirect_valid, misalign;
    logic [31:0] out_rd_value, out_next_pc, redirect_pc;

    int vectors = 0;
    int miscompares = 0;

    exec_pipe_unit #(.XLEN(XLEN), .SHAMT_W(5), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_rd_value(out_rd_value), .out_next_pc(out_next_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Record as {valid, we, value, next_pc}.
    function automatic logic [65:0] rec();
        return {out_valid, out_rd_we, out_rd_value, out_next_pc};
    endfunction

    // Presents one op for a single edge; callers are positioned 1ns after a rising edge.
    task automatic issue(input exec_op_t op, input logic [31:0] pc, a, b, imm, input logic [4:0] rd);
        in_op = op; in_pc = pc; in_rs1_val = a; in_rs2_val = b; in_imm = imm; in_rd = rd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Issues a divide and counts cycles from acceptance until out_valid, bounded at 200.
    task automatic run_div(input exec_op_t op, input logic [31:0] a, b, output int lat, output logic ready_hi);
        issue(op, 32'h400, a, b, 32'h0, 5'd7);
        lat = 1;
        ready_hi = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_hi = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [104:0] got;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_op = OP_NOP;
        in_pc = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        got = {out_valid, out_rd, out_rd_we, out_rd_value, out_next_pc, redirect_valid, redirect_pc, misalign};
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", got);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_alu();
        exec_op_t    ops [13] = '{OP_ADD, OP_SUB, OP_SRA, OP_SRL, OP_SLL, OP_SRAI, OP_SLT,
                                  OP_SLTU, OP_SLTIU, OP_XORI, OP_LUI, OP_AUIPC, OP_ANDI};
        logic [31:0] as  [13] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'd1, 32'h80000001,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hF0F0F0F0, 32'd0, 32'd0, 32'hFFFF00FF};
        logic [31:0] bs  [13] = '{32'd1, 32'd7, 32'h21, 32'h21, 32'h1F, 32'h1F,
                                  32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] ims [13] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345000, 32'h1000, 32'h0F0F0F0F};
        logic [31:0] exp [13] = '{32'h80000000, 32'hFFFFFFFE, 32'hC0000000, 32'h40000000, 32'h80000000,
                                  32'h80000001, 32'd1, 32'd0, 32'd1, 32'h0F0F0F0F, 32'h12345000,
                                  32'h0000122C, 32'h0F0F000F};
        logic [31:0] pc;
        for (int i = 0; i < 13; i++) begin
            pc = 32'h200 + 32'(4 * i);
            issue(ops[i], pc, as[i], bs[i], ims[i], 5'd5);
            vectors++;
            if (rec() !== {1'b1, 1'b1, exp[i], pc + 32'd4} || out_rd !== 5'd5) begin
                miscompares++;
                $display("[TB] FAIL alu_%0d: got rec %h rd %0d expected %h rd 5", i, rec(), out_rd,
                         {1'b1, 1'b1, exp[i], pc + 32'd4});
            end
        end
        issue(OP_ADD, 32'h280, 32'd3, 32'd4, 32'd0, 5'd0);
        vectors++;
        if (rec() !== {1'b1, 1'b0, 32'd7, 32'h284}) begin
            miscompares++;
            $display("[TB] FAIL rd_zero: got %h expected %h", rec(), {1'b1, 1'b0, 32'd7, 32'h284});
        end
        issue(exec_op_t'(6'h3F), 32'h290, 32'd3, 32'd4, 32'd0, 5'd9);
        vectors++;
        if ({out_valid, out_rd_we, out_next_pc, redirect_valid} !== {1'b1, 1'b0, 32'h294, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL unknown_op: got %h expected %h", {out_valid, out_rd_we, out_next_pc, redirect_valid},
                     {1'b1, 1'b0, 32'h294, 1'b0});
        end
    endtask

    task automatic test_control();
        issue(OP_BLT, 32'h100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 5'd3);
        vectors++;
        if ({redirect_valid, redirect_pc, misalign, out_rd_we, out_next_pc} !== {1'b1, 32'hF8, 1'b0, 1'b0, 32'hF8}) begin
            miscompares++;
            $display("[TB] FAIL blt_taken: got %h expected %h",
                     {redirect_valid, redirect_pc, misalign, out_rd_we, out_next_pc}, {1'b1, 32'hF8, 1'b0, 1'b0, 32'hF8});
        end
        @(posedge clk); #1;
        vectors++;
        if (redirect_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL redirect_pulse: got %b expected 0", redirect_valid);
        end
        issue(OP_BLT, 32'h100, 32'd2, 32'd1, 32'hFFFFFFF8, 5'd3);
        vectors++;
        if ({out_valid, redirect_valid, out_rd_we, out_next_pc} !== {1'b1, 1'b0, 1'b0, 32'h104}) begin
            miscompares++;
            $display("[TB] FAIL blt_not_taken: got %h expected %h",
                     {out_valid, redirect_valid, out_rd_we, out_next_pc}, {1'b1, 1'b0, 1'b0, 32'h104});
        end
        issue(OP_JAL, 32'h300, 32'd0, 32'd0, 32'h10, 5'd1);
        vectors++;
        if ({rec(), redirect_valid, redirect_pc, misalign} !== {1'b1, 1'b1, 32'h304, 32'h310, 1'b1, 32'h310, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL jal: got %h expected %h", {rec(), redirect_valid, redirect_pc, misalign},
                     {1'b1, 1'b1, 32'h304, 32'h310, 1'b1, 32'h310, 1'b0});
        end
        issue(OP_JALR, 32'h40, 32'h1003, 32'd0, 32'd0, 5'd1);
        vectors++;
        if ({rec(), redirect_valid, redirect_pc, misalign} !== {1'b1, 1'b0, 32'h44, 32'h1002, 1'b1, 32'h1002, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL jalr_misalign: got %h expected %h", {rec(), redirect_valid, redirect_pc, misalign},
                     {1'b1, 1'b0, 32'h44, 32'h1002, 1'b1, 32'h1002, 1'b1});
        end
    endtask

    task automatic test_divide();
        exec_op_t    ops [9] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_REMU};
        logic [31:0] as  [9] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h1234, 32'hFFFFFFF9,
                                 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs  [9] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        logic [31:0] exp [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                 32'h80000000, 32'd0, 32'h7FFFFFFE};
        int          lats[9] = '{XLEN + 2, XLEN + 2, XLEN + 2, XLEN + 2, 2, 2, 2, 2, XLEN + 2};
        int          lat;
        logic        ready_hi;
        for (int i = 0; i < 9; i++) begin
            run_div(ops[i], as[i], bs[i], lat, ready_hi);
            vectors++;
            if (rec() !== {1'b1, 1'b1, exp[i], 32'h404} || lat != lats[i] || ready_hi !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL div_%0d: got rec %h lat %0d ready_seen %b expected rec %h lat %0d ready_seen 0",
                         i, rec(), lat, ready_hi, {1'b1, 1'b1, exp[i], 32'h404}, lats[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_op = OP_ADD; in_rs1_val = 32'(i + 1); in_rs2_val = 32'd10; in_imm = '0;
            in_pc = 32'h500 + 32'(4 * i); in_rd = 5'd2;
            @(posedge clk); #1;
            vectors++;
            if ({rec(), in_ready} !== {1'b1, 1'b1, 32'(11 + i), 32'h504 + 32'(4 * i), 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL back_to_back_%0d: got %h expected %h", i, {rec(), in_ready},
                         {1'b1, 1'b1, 32'(11 + i), 32'h504 + 32'(4 * i), 1'b1});
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(OP_ADD, 32'h600, 32'd3, 32'd4, 32'd0, 5'd4);
        in_op = OP_ADD; in_rs1_val = 32'd100; in_rs2_val = 32'd100; in_pc = 32'h700; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({rec(), in_ready} !== {1'b1, 1'b1, 32'd7, 32'h604, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL hold_stable: got %h expected %h", {rec(), in_ready}, {1'b1, 1'b1, 32'd7, 32'h604, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (rec() !== {1'b1, 1'b1, 32'd200, 32'h704}) begin
            miscompares++;
            $display("[TB] FAIL replace_same_edge: got %h expected %h", rec(), {1'b1, 1'b1, 32'd200, 32'h704});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic seen;
        issue(OP_DIV, 32'h800, 32'd100, 32'd7, 32'd0, 5'd6);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < XLEN + 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if ({seen, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL flush_div_abort: got seen_valid,in_ready %b expected 01", {seen, in_ready});
        end
        in_op = OP_ADD; in_rs1_val = 32'd1; in_rs2_val = 32'd1; in_pc = 32'h900; in_rd = 5'd3;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_blocks_accept: got out_valid %b expected 0", out_valid);
        end
        out_ready = 1'b0;
        issue(OP_ADD, 32'hA00, 32'd5, 32'd6, 32'd0, 5'd3);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        vectors++;
        if ({out_valid, redirect_valid, in_ready} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL flush_pending: got %b expected 001", {out_valid, redirect_valid, in_ready});
        end
        out_ready = 1'b1;
        issue(OP_ADD, 32'hB00, 32'd20, 32'd22, 32'd0, 5'd8);
        vectors++;
        if ({rec(), out_rd} !== {1'b1, 1'b1, 32'd42, 32'hB04, 5'd8}) begin
            miscompares++;
            $display("[TB] FAIL add_after_flush: got %h expected %h", {rec(), out_rd}, {1'b1, 1'b1, 32'd42, 32'hB04, 5'd8});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        issue(OP_DIVU, 32'hC00, 32'd1000, 32'd3, 32'd0, 5'd9);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < XLEN + 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if ({seen, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_div: got seen_valid,in_ready %b expected 01", {seen, in_ready});
        end
    endtask

    initial begin
        $display("[TB] exec_pipe_unit directed bench starting");
        test_reset();
        test_alu();
        test_control();
        test_divide();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_pipe_unit.md
Name: exec_pipe_unit

Overview:
- Parametrised RV32I/RV64I execute stage, placed between decode and writeback; successor to the single-cycle combinational execute.
- Consumes one decoded, operand-resolved micro-op per valid/ready handshake and produces a registered writeback record.
- Resolves branches and jumps and issues a redirect/flush request to fetch.
- Adds an iterative M-extension divider with stall and abort.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- SHAMT_W, $clog2(XLEN), width of shift amount taken from operand low bits.
- REG_ADDR_W, 5, width of register index.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush from a younger-stage redirect
- in_valid  in  1  decoded op present
- in_ready  out  1  unit accepts op this cycle
- in_op  in  exec_op_t  operation (package enum)
- in_pc  in  XLEN  instruction PC
- in_rs1_val  in  XLEN  rs1 operand
- in_rs2_val  in  XLEN  rs2 operand
- in_imm  in  XLEN  immediate, already sign-extended by decode
- in_rd  in  REG_ADDR_W  destination register index
- out_valid  out  1  writeback record valid
- out_ready  in  1  writeback accepts record
- out_rd  out  REG_ADDR_W  destination index
- out_rd_we  out  1  register write enable; 0 for branches and when rd==0
- out_rd_value  out  XLEN  result
- out_next_pc  out  XLEN  architectural next PC
- redirect_valid  out  1  taken branch/jump pulse
- redirect_pc  out  XLEN  redirect target
- misalign  out  1  target[1:0] != 0 on taken control transfer

Behaviour:
- Reset values: all outputs 0; state IDLE; in_ready is 1 in the cycle after rst deasserts.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output record holds stable while out_valid && !out_ready.
- Single-cycle ops:
  - Covers ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, their immediate forms, LUI/AUIPC, JAL/JALR, BEQ..BGEU.
  - Result is registered: out_valid rises the cycle after acceptance.
  - out_next_pc = in_pc+4 unless taken.
- Shifts:
  - Amount = operand[SHAMT_W-1:0].
  - SRA/SRAI are arithmetic (sign-fill).
  - Shift by 0 returns the operand unchanged.
- Set-less-than: SLT/SLTI signed compare; SLTU/SLTIU unsigned compare of zero-extended bit pattern.
- Control transfer:
  - Branch target = in_pc+in_imm.
  - JAL target = in_pc+in_imm, rd_value = in_pc+4.
  - JALR target = (rs1+imm) & ~1, rd_value = in_pc+4.
  - Taken: out_next_pc = target; redirect_valid high for exactly the one cycle the record is first loaded; redirect_pc = target.
  - misalign is set under the same conditions; out_rd_we is forced 0 when misalign is set.
- Divider (DIV/DIVU/REM/REMU):
  - FSM IDLE -> BUSY (XLEN cycles, radix-2 restoring) -> DONE (1 cycle, sign fix, load output) -> IDLE.
  - Latency from acceptance to out_valid = XLEN+2 cycles.
  - in_ready = 0 outside IDLE.
  - Divide by zero: quotient all ones; remainder = dividend; BUSY is skipped and the result is loaded next cycle.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0; also skips BUSY.
- Flush:
  - flush has priority over rst-free activity and any same-cycle in_valid; the op is not accepted.
  - Clears out_valid and redirect_valid next cycle.
  - Aborts the divider to IDLE.
- Simultaneous out_ready and new in_valid: the record is replaced in the same edge, giving full throughput of 1 op/cycle for single-cycle ops.
- rst mid-division: returns to IDLE; no output is produced.
- Unknown in_op: treated as NOP; out_rd_we = 0, next_pc = pc+4.

Optional Feature:
- Macro EXEC_PIPE_MUL_EN.
- When defined:
  - MUL/MULH/MULHSU/MULHU are decoded as 2-cycle ops.
  - Operands are registered, a 2*XLEN product is formed, then the low or high half is selected.
  - FSM adds state MUL; in_ready = 0 during it.
- When undefined:
  - Those in_op values are treated as unknown (NOP), with no multiplier logic.
  - Illegal-op signalling remains decode's responsibility.

Decomposition:
- Package defs gains:
  - exec_op_t enum;
  - exec_state_t {IDLE,BUSY,DONE,MUL};
  - constants PC_STEP=4 and DIV_ZERO_Q='1.
- Sub-module exec_div_iter holds the iterative divider:
  - start/abort/busy/done interface;
  - unsigned core;
  - sign handling in the parent.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1 -> next cycle out_valid, rd_value=0x80000000, we=1, next_pc=pc+4.
- SRA rs1=0x80000000, rs2=0x21 -> shamt=1, rd_value=0xC0000000.
- BLT rs1=-1, rs2=1, pc=0x100, imm=-8 -> redirect_valid one-cycle pulse, redirect_pc=0xF8, we=0; with rs1=2 no redirect.
- JALR rs1=0x1003, imm=0, pc=0x40 -> target 0x1002, rd_value=0x44, misalign=1, we=0.
- DIV -7/2 -> out_valid after XLEN+2 cycles, rd_value=-3, in_ready low throughout; REM gives -1.
  - DIVU x/0 -> 0xFFFFFFFF in 2 cycles.
  - DIV 0x80000000/-1 -> 0x80000000.
- Flush at cycle 5 of a divide, plus out_ready held low with a pending record -> out_valid drops next cycle; in_ready high; a subsequent ADD completes normally.
